// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the staged reset-release controller.
// Holds the sequencer state enum, default parameters and the counter-width helper.
package reset_seq_pkg;

    localparam int DEF_NUM_STAGES  = 4;
    localparam int DEF_MIN_ASSERT  = 8;
    localparam int DEF_STAGE_DLY   = 16;
    localparam int DEF_WDT_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } seq_state_t;

    // Width able to hold max(a,b)-1 with one spare bit of headroom.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Request/acknowledge handshake and sequenced reset outputs of reset_sequencer.
// Watchdog signals exist only when RST_SEQ_WDT_EN is defined.
interface reset_sequencer_if
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES
);

    logic                  sw_rst_req;
    logic                  sw_rst_ack;
    logic [NUM_STAGES-1:0] stage_rst_n;
    logic                  done;
`ifdef RST_SEQ_WDT_EN
    logic                  wdt_kick;
    logic                  wdt_fired;

    modport master (
        output sw_rst_req,
        input  sw_rst_ack,
        input  stage_rst_n,
        input  done,
        output wdt_kick,
        input  wdt_fired
    );

    modport slave (
        input  sw_rst_req,
        output sw_rst_ack,
        output stage_rst_n,
        output done,
        input  wdt_kick,
        output wdt_fired
    );
`else
    modport master (
        output sw_rst_req,
        input  sw_rst_ack,
        input  stage_rst_n,
        input  done
    );

    modport slave (
        input  sw_rst_req,
        output sw_rst_ack,
        output stage_rst_n,
        output done
    );
`endif

endinterface

// File: rtl/reset_seq_timer.sv
// Loadable saturating down-counter; 'expired' is high while the count sits at zero.
// Used both for the per-phase delays and for the watchdog.
module reset_seq_timer
    import reset_seq_pkg::*;
#(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RST_VAL;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset-release controller: holds all stage resets, then releases them in order,
// re-entering on a four-phase software request. Optional watchdog: define RST_SEQ_WDT_EN.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES  = DEF_NUM_STAGES,
    parameter int MIN_ASSERT  = DEF_MIN_ASSERT,
    parameter int STAGE_DLY   = DEF_STAGE_DLY
`ifdef RST_SEQ_WDT_EN
    ,
    parameter int WDT_TIMEOUT = DEF_WDT_TIMEOUT
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    reset_sequencer_if.slave bus
);

    localparam int CW = cnt_width(MIN_ASSERT, STAGE_DLY);
    localparam int IW = $clog2(NUM_STAGES) + 1;

    // The phase timer counts down, so "cnt reached N-1" becomes "loaded N-1, now zero".
    localparam logic [CW-1:0] HOLD_LOAD = CW'(MIN_ASSERT - 1);
    localparam logic [CW-1:0] STEP_LOAD = CW'(STAGE_DLY - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_STAGES - 1);

    seq_state_t            state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  done_q, done_d;
    logic                  ack_q, ack_d;

    logic                  ph_load;
    logic [CW-1:0]         ph_load_val;
    logic                  ph_expired;
    logic                  wdt_exp;
    logic                  reenter;

    reset_seq_timer #(
        .W       (CW),
        .RST_VAL (HOLD_LOAD)
    ) u_phase_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ph_load),
        .load_val (ph_load_val),
        .expired  (ph_expired)
    );

`ifdef RST_SEQ_WDT_EN
    localparam int            WW       = cnt_width(WDT_TIMEOUT, 1);
    localparam logic [WW-1:0] WDT_LOAD = WW'(WDT_TIMEOUT - 1);

    logic wdt_load;
    logic wdt_zero;
    logic fired_q;

    // Held at full count outside RUN so the window always starts at RUN entry or a kick.
    assign wdt_load = (state_q != RUN) || bus.wdt_kick;
    assign wdt_exp  = (state_q == RUN) && wdt_zero && !bus.wdt_kick;

    reset_seq_timer #(
        .W       (WW),
        .RST_VAL (WDT_LOAD)
    ) u_wdt_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (wdt_load),
        .load_val (WDT_LOAD),
        .expired  (wdt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fired_q <= 1'b0;
        end else if (wdt_exp) begin
            fired_q <= 1'b1;
        end
    end

    assign bus.wdt_fired = fired_q;
`else
    assign wdt_exp = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ASSERT;
            idx_q   <= '0;
            stage_q <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        stage_d     = stage_q;
        done_d      = done_q;
        ack_d       = ack_q;
        ph_load     = 1'b0;
        ph_load_val = HOLD_LOAD;
        reenter     = 1'b0;

        case (state_q)
            ASSERT: begin
                // A request held high keeps reloading the hold time.
                if (bus.sw_rst_req) begin
                    ph_load     = 1'b1;
                    ph_load_val = HOLD_LOAD;
                end else if (ph_expired) begin
                    state_d     = RELEASE;
                    idx_d       = '0;
                    ph_load     = 1'b1;
                    ph_load_val = STEP_LOAD;
                end
            end

            RELEASE: begin
                if (bus.sw_rst_req) begin
                    reenter = 1'b1;
                    ack_d   = 1'b1;
                end else if (ph_expired) begin
                    for (int i = 0; i < NUM_STAGES; i++) begin
                        if (idx_q == IW'(i)) begin
                            stage_d[i] = 1'b1;
                        end
                    end
                    idx_d       = idx_q + 1'b1;
                    ph_load     = 1'b1;
                    ph_load_val = STEP_LOAD;
                    if (idx_q == LAST_IDX) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                        ack_d   = 1'b0;
                    end
                end
            end

            RUN: begin
                if (bus.sw_rst_req || wdt_exp) begin
                    reenter = 1'b1;
                    if (bus.sw_rst_req) begin
                        ack_d = 1'b1;
                    end
                end
            end

            default: begin
                reenter = 1'b1;
            end
        endcase

        // Every re-entry drops all stages together, never a subset.
        if (reenter) begin
            state_d     = ASSERT;
            idx_d       = '0;
            stage_d     = '0;
            done_d      = 1'b0;
            ph_load     = 1'b1;
            ph_load_val = HOLD_LOAD;
        end
    end

    assign bus.stage_rst_n = stage_q;
    assign bus.done        = done_q;
    assign bus.sw_rst_ack  = ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios then randomized requests/resets, every edge
// checked against an age-since-sequence-start reference model.
module tb_reset_sequencer;
    import reset_seq_pkg::*;

    localparam int N   = 4;
    localparam int MIN = 8;
    localparam int DLY = 16;
    localparam int D   = MIN + N * DLY;
`ifdef RST_SEQ_WDT_EN
    localparam int WDT = 32;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    reset_sequencer_if #(.NUM_STAGES(N)) bus ();

    reset_sequencer #(
        .NUM_STAGES  (N),
        .MIN_ASSERT  (MIN),
        .STAGE_DLY   (DLY)
`ifdef RST_SEQ_WDT_EN
        ,
        .WDT_TIMEOUT (WDT)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: age = edges since the sequence (re)started.
    int n_cmp   = 0;
    int n_fail  = 0;
    int age     = 0;
    int edge_no = 0;
    bit ack_m   = 1'b0;
`ifdef RST_SEQ_WDT_EN
    int wdog    = 0;
    bit fired_m = 1'b0;
`endif

    function automatic logic [N-1:0] exp_stages(input int a);
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) r[k] = (a >= MIN + (k + 1) * DLY);
        return r;
    endfunction

    task automatic model_reset();
        age     = 0;
        edge_no = 0;
        ack_m   = 1'b0;
`ifdef RST_SEQ_WDT_EN
        wdog    = 0;
        fired_m = 1'b0;
`endif
    endtask

    task automatic model_edge();
        bit req;
        bit wexp;
        req  = bus.sw_rst_req;
        wexp = 1'b0;
`ifdef RST_SEQ_WDT_EN
        begin
            bit in_run;
            bit kick;
            kick   = bus.wdt_kick;
            in_run = (age >= D);
            wexp   = in_run && !kick && (wdog + 1 >= WDT);
            if (!in_run || kick) wdog = 0;
            else wdog = wdog + 1;
            if (wexp) fired_m = 1'b1;
        end
`endif
        if (req || wexp) begin
            if (req && (age + 1 > MIN)) ack_m = 1'b1;
            age = 0;
        end else if (age <= D) begin
            age = age + 1;
        end
        if (age == D) ack_m = 1'b0;
        edge_no = edge_no + 1;
    endtask

    task automatic check(input string tag);
        logic [N-1:0] want_stage;
        want_stage = exp_stages(age);
        n_cmp++;
        assert (bus.stage_rst_n === want_stage) else begin
            n_fail++;
            $error("FAIL %s stage_rst_n edge=%0d got=%b want=%b", tag, edge_no, bus.stage_rst_n, want_stage);
        end
        n_cmp++;
        assert (bus.done === (age >= D)) else begin
            n_fail++;
            $error("FAIL %s done edge=%0d got=%b want=%b", tag, edge_no, bus.done, (age >= D));
        end
        n_cmp++;
        assert (bus.sw_rst_ack === ack_m) else begin
            n_fail++;
            $error("FAIL %s sw_rst_ack edge=%0d got=%b want=%b", tag, edge_no, bus.sw_rst_ack, ack_m);
        end
`ifdef RST_SEQ_WDT_EN
        n_cmp++;
        assert (bus.wdt_fired === fired_m) else begin
            n_fail++;
            $error("FAIL %s wdt_fired edge=%0d got=%b want=%b", tag, edge_no, bus.wdt_fired, fired_m);
        end
`endif
    endtask

    task automatic step(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            check(tag);
        end
    endtask

    // Called 1 ns after a rising edge; low phase must end before the next edge.
    task automatic pulse_reset(input int low_ns);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_async");
        #(low_ns - 1);
        rst_n = 1'b1;
    endtask

    task automatic hold_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic request(input int extra);
        bus.sw_rst_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1, "rnd_req");
            if (bus.sw_rst_ack === 1'b1) break;
        end
        step(extra, "rnd_req_hold");
        bus.sw_rst_req = 1'b0;
    endtask

    initial begin
        bus.sw_rst_req = 1'b0;
`ifdef RST_SEQ_WDT_EN
        bus.wdt_kick = 1'b0;
`endif
        #2;
        hold_reset(3);

        // Power-on: releases expected at edges 24/40/56/72, ack never raised.
        step(100, "poweron");

        // Request in RUN, held for three edges after ack.
        bus.sw_rst_req = 1'b1;
        step(1, "req_ack");
        step(3, "req_hold");
        bus.sw_rst_req = 1'b0;
        step(80, "req_resequence");

        // Long request keeps everything in reset.
        bus.sw_rst_req = 1'b1;
        step(200, "req_long");
        bus.sw_rst_req = 1'b0;
        step(D + 10, "after_long");

        // Asynchronous reset mid-RELEASE.
        pulse_reset(7);
        step(45, "pre_pulse");
        pulse_reset(7);
        step(D + 10, "restart");

        // Request sampled on the edge where stage 1 would release.
        pulse_reset(7);
        step(39, "to_edge39");
        bus.sw_rst_req = 1'b1;
        step(1, "req_at_40");
        step(2, "req_at_40_hold");
        bus.sw_rst_req = 1'b0;
        step(D + 5, "after_40");

`ifdef RST_SEQ_WDT_EN
        step(WDT + 10, "wdt_fire");
        step(D + 2, "wdt_resequence");
        for (int i = 0; i < 10; i++) begin
            bus.wdt_kick = 1'b1;
            step(1, "wdt_kick");
            bus.wdt_kick = 1'b0;
            step(19, "wdt_kicked");
        end
        for (int i = 0; i < D + WDT + 10; i++) begin
            if (age >= D && wdog == WDT - 1) break;
            step(1, "wdt_align");
        end
        bus.sw_rst_req = 1'b1;
        step(1, "wdt_and_req");
        step(2, "wdt_and_req_hold");
        bus.sw_rst_req = 1'b0;
        step(D + 5, "after_wdt_req");
`endif

        for (int it = 0; it < 40; it++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel <= 4 || (sel <= 7 && ack_m)) begin
                int len;
                len = $urandom_range(1, 120);
                for (int i = 0; i < len; i++) begin
`ifdef RST_SEQ_WDT_EN
                    bus.wdt_kick = ($urandom_range(0, 40) == 0);
`endif
                    step(1, "rnd_idle");
                end
`ifdef RST_SEQ_WDT_EN
                bus.wdt_kick = 1'b0;
`endif
            end else if (sel <= 7) begin
                request($urandom_range(0, 4));
            end else if (sel == 8) begin
                pulse_reset($urandom_range(2, 7));
            end else begin
                hold_reset($urandom_range(1, 4));
            end
        end
        step(D + 5, "final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
